// File: rtl/csi2_vc_demux_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// csi2_pkg : data-type codes, per-VC state encoding and error bit positions
// Rev 1.0
//----------------------------------------------------------------------------
package csi2_pkg;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_LS    = 6'h02;
   localparam logic [5:0] DT_LE    = 6'h03;
   localparam logic [5:0] DT_RAW8  = 6'h2A;
   localparam logic [5:0] DT_RAW10 = 6'h2B;
   localparam logic [5:0] DT_RAW12 = 6'h2C;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_LINE  = 2'd2
   } vc_state_t;

   // err vector is {no_fs, no_fe, len, trunc, crc}
   localparam int c_ERR_W     = 5;
   localparam int c_ERR_NO_FS = 4;
   localparam int c_ERR_NO_FE = 3;
   localparam int c_ERR_LEN   = 2;
   localparam int c_ERR_TRUNC = 1;
   localparam int c_ERR_CRC   = 0;

   function automatic logic [2:0] popcount4(input logic [3:0] be);
      return {2'b00, be[0]} + {2'b00, be[1]} + {2'b00, be[2]} + {2'b00, be[3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/csi2_vc_demux_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// csi2_vc_demux_if : packet-handler input streams and per-VC output streams
// Rev 1.0
//----------------------------------------------------------------------------
interface csi2_vc_demux_if #(
   parameter int VC_CNT     = 4,
   parameter int LINE_CNT_W = 12
);
   logic                         short_pkt_valid_i;
   logic [1:0]                   short_pkt_v_channel_i;
   logic [5:0]                   short_pkt_data_type_i;
   logic [15:0]                  short_pkt_data_field_i;
   logic                         long_pkt_header_valid_i;
   logic [1:0]                   long_pkt_v_channel_i;
   logic [5:0]                   long_pkt_data_type_i;
   logic [15:0]                  long_pkt_word_cnt_i;
   logic [31:0]                  long_pkt_payload_i;
   logic                         long_pkt_payload_valid_i;
   logic [3:0]                   long_pkt_payload_be_i;
   logic                         long_pkt_eop_i;
   logic                         crc_passed_i;
   logic                         crc_failed_i;
   logic [VC_CNT*32-1:0]         vc_tdata_o;
   logic [VC_CNT*4-1:0]          vc_tstrb_o;
   logic [VC_CNT-1:0]            vc_tvalid_o;
   logic [VC_CNT-1:0]            vc_tuser_o;
   logic [VC_CNT-1:0]            vc_tlast_o;
   logic [VC_CNT-1:0]            frame_active_o;
   logic [VC_CNT*16-1:0]         frame_num_o;
   logic [VC_CNT*LINE_CNT_W-1:0] line_cnt_o;
   logic [VC_CNT*5-1:0]          err_o;

   modport master (
      output short_pkt_valid_i, short_pkt_v_channel_i, short_pkt_data_type_i,
             short_pkt_data_field_i, long_pkt_header_valid_i, long_pkt_v_channel_i,
             long_pkt_data_type_i, long_pkt_word_cnt_i, long_pkt_payload_i,
             long_pkt_payload_valid_i, long_pkt_payload_be_i, long_pkt_eop_i,
             crc_passed_i, crc_failed_i,
      input  vc_tdata_o, vc_tstrb_o, vc_tvalid_o, vc_tuser_o, vc_tlast_o,
             frame_active_o, frame_num_o, line_cnt_o, err_o
   );

   modport slave (
      input  short_pkt_valid_i, short_pkt_v_channel_i, short_pkt_data_type_i,
             short_pkt_data_field_i, long_pkt_header_valid_i, long_pkt_v_channel_i,
             long_pkt_data_type_i, long_pkt_word_cnt_i, long_pkt_payload_i,
             long_pkt_payload_valid_i, long_pkt_payload_be_i, long_pkt_eop_i,
             crc_passed_i, crc_failed_i,
      output vc_tdata_o, vc_tstrb_o, vc_tvalid_o, vc_tuser_o, vc_tlast_o,
             frame_active_o, frame_num_o, line_cnt_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/csi2_vc_tracker.sv
`default_nettype none
//----------------------------------------------------------------------------
// csi2_vc_tracker : frame/line state, frame number, line count and errors
//                   for one virtual channel
// Rev 1.0
//----------------------------------------------------------------------------
module csi2_vc_tracker
   import csi2_pkg::*;
#(
   parameter int LINE_CNT_W = 12
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  i_fs,
   input  wire logic                  i_fe,
   input  wire logic [15:0]           i_fs_field,
   input  wire logic                  i_hdr,
   input  wire logic                  i_pay,
   input  wire logic                  i_eop,
   input  wire logic                  i_len_err,
   input  wire logic                  i_crc_err,
   output logic                       o_hdr_take,
   output logic                       o_in_line,
   output logic                       o_frame_active,
   output logic                       o_sof_pend,
   output logic [15:0]                o_frame_num,
   output logic [LINE_CNT_W-1:0]      o_line_cnt,
   output logic [c_ERR_W-1:0]         o_err
);

   vc_state_t               r_state, w_state_nxt, w_mid;
   logic [15:0]             r_frame_num;
   logic [LINE_CNT_W-1:0]   r_line_cnt;
   logic                    r_sof_pend;
   logic [c_ERR_W-1:0]      r_err, w_err;
   logic                    w_restart, w_line_inc, w_hdr_take;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Short packets act first; a header in the same cycle sees the result.
   always_comb begin
      w_mid       = r_state;
      w_state_nxt = r_state;
      w_err       = '0;
      w_restart   = 1'b0;
      w_line_inc  = 1'b0;
      w_hdr_take  = 1'b0;
      if (i_fs) begin
         w_err[c_ERR_NO_FE] = (r_state != ST_IDLE);
         w_mid              = ST_FRAME;
         w_restart          = 1'b1;
      end else if (i_fe) begin
         w_err[c_ERR_NO_FS] = (r_state == ST_IDLE);
         w_err[c_ERR_TRUNC] = (r_state == ST_LINE);
         w_mid              = ST_IDLE;
      end else if (i_eop && r_state == ST_LINE) begin
         w_mid      = ST_FRAME;
         w_line_inc = 1'b1;
      end
      w_state_nxt = w_mid;
      if (i_hdr) begin
         if (w_mid == ST_FRAME) begin
            w_state_nxt = ST_LINE;
            w_hdr_take  = 1'b1;
         end else if (w_mid == ST_IDLE) begin
            w_err[c_ERR_NO_FS] = 1'b1;
         end
      end
      w_err[c_ERR_LEN] = i_len_err;
      w_err[c_ERR_CRC] = i_crc_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_num <= '0;
         r_line_cnt  <= '0;
         r_sof_pend  <= 1'b0;
         r_err       <= '0;
      end else begin
         r_err <= w_err;
         if (w_restart) begin
            r_frame_num <= i_fs_field;
            r_line_cnt  <= '0;
         end else if (w_line_inc) begin
            r_line_cnt  <= r_line_cnt + 1'b1;
         end
         if (w_restart)  r_sof_pend <= 1'b1;
         else if (i_pay) r_sof_pend <= 1'b0;
      end
   end

   assign o_hdr_take     = w_hdr_take;
   assign o_in_line      = (r_state == ST_LINE);
   assign o_frame_active = (r_state != ST_IDLE);
   assign o_sof_pend     = r_sof_pend;
   assign o_frame_num    = r_frame_num;
   assign o_line_cnt     = r_line_cnt;
   assign o_err          = r_err;

endmodule
`default_nettype wire

// File: rtl/csi2_vc_demux.sv
`default_nettype none
//----------------------------------------------------------------------------
// csi2_vc_demux : routes CSI-2 pixel payload to per-virtual-channel streams
//                 with frame/line tracking and per-VC error reporting
// Rev 1.0
//----------------------------------------------------------------------------
module csi2_vc_demux
   import csi2_pkg::*;
#(
   parameter int         VC_CNT        = 4,
   parameter logic [5:0] PIXEL_DT      = 6'h2B,
   parameter bit         ACCEPT_ALL_DT = 1'b0,
   parameter int         LINE_CNT_W    = 12
) (
   input wire logic         clk_i,
   input wire logic         rst_i,
   csi2_vc_demux_if.slave   bus
);

   logic                    w_dt_ok, w_vc_ok, w_hdr_acc, w_take_any, w_route;
   logic                    w_in_line  [4];
   logic                    w_sof_pend [4];
   logic                    w_hdr_take [4];
   logic [VC_CNT-1:0]       w_pay_vec;
   logic [15:0]             w_byte_sum;
   logic                    w_unused;

   logic                    w_frame_active [VC_CNT];
   logic [15:0]             w_frame_num    [VC_CNT];
   logic [LINE_CNT_W-1:0]   w_line_cnt     [VC_CNT];
   logic [c_ERR_W-1:0]      w_err          [VC_CNT];

   logic [1:0]              r_active_vc, r_crc_vc;
   logic                    r_drop, r_crc_arm;
   logic [15:0]             r_byte_cnt, r_word_cnt;
   logic [31:0]             r_tdata [VC_CNT];
   logic [3:0]              r_tstrb [VC_CNT];
   logic [VC_CNT-1:0]       r_tvalid, r_tuser, r_tlast;

   assign w_unused   = bus.crc_passed_i;
   assign w_dt_ok    = ACCEPT_ALL_DT ? (bus.long_pkt_data_type_i >= 6'h10)
                                     : (bus.long_pkt_data_type_i == PIXEL_DT);
   assign w_vc_ok    = (32'(bus.long_pkt_v_channel_i) < VC_CNT);
   assign w_hdr_acc  = bus.long_pkt_header_valid_i && w_dt_ok && w_vc_ok;
   assign w_route    = bus.long_pkt_payload_valid_i && !r_drop && w_in_line[r_active_vc];
   assign w_byte_sum = r_byte_cnt + 16'(popcount4(bus.long_pkt_payload_be_i));

   always_comb begin
      w_take_any = 1'b0;
      w_pay_vec  = '0;
      for (int v = 0; v < 4; v++) w_take_any = w_take_any | w_hdr_take[v];
      for (int v = 0; v < VC_CNT; v++) w_pay_vec[v] = w_route && (r_active_vc == 2'(v));
   end

   for (genvar v = 0; v < 4; v++) begin : g_vc
      if (v < VC_CNT) begin : g_on
         logic w_short_hit;
         assign w_short_hit = bus.short_pkt_valid_i && (bus.short_pkt_v_channel_i == 2'(v));

         csi2_vc_tracker #(.LINE_CNT_W(LINE_CNT_W)) u_trk (
            .clk            (clk_i),
            .rst            (rst_i),
            .i_fs           (w_short_hit && bus.short_pkt_data_type_i == DT_FS),
            .i_fe           (w_short_hit && bus.short_pkt_data_type_i == DT_FE),
            .i_fs_field     (bus.short_pkt_data_field_i),
            .i_hdr          (w_hdr_acc && bus.long_pkt_v_channel_i == 2'(v)),
            .i_pay          (w_pay_vec[v]),
            .i_eop          (w_pay_vec[v] && bus.long_pkt_eop_i),
            .i_len_err      (w_pay_vec[v] && bus.long_pkt_eop_i && (w_byte_sum != r_word_cnt)),
            .i_crc_err      (bus.crc_failed_i && r_crc_arm && r_crc_vc == 2'(v)),
            .o_hdr_take     (w_hdr_take[v]),
            .o_in_line      (w_in_line[v]),
            .o_frame_active (w_frame_active[v]),
            .o_sof_pend     (w_sof_pend[v]),
            .o_frame_num    (w_frame_num[v]),
            .o_line_cnt     (w_line_cnt[v]),
            .o_err          (w_err[v])
         );
      end else begin : g_off
         assign w_in_line[v]  = 1'b0;
         assign w_sof_pend[v] = 1'b0;
         assign w_hdr_take[v] = 1'b0;
      end
   end

   // Any header that does not open a line makes its payload invisible until eop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_active_vc <= '0;
         r_drop      <= 1'b0;
         r_byte_cnt  <= '0;
         r_word_cnt  <= '0;
         r_crc_vc    <= '0;
         r_crc_arm   <= 1'b0;
      end else begin
         if (w_route) r_byte_cnt <= w_byte_sum;
         if (bus.long_pkt_payload_valid_i && bus.long_pkt_eop_i) r_drop <= 1'b0;
         if (bus.long_pkt_header_valid_i) begin
            r_drop    <= !w_take_any;
            r_crc_arm <= w_take_any;
            if (w_take_any) begin
               r_active_vc <= bus.long_pkt_v_channel_i;
               r_crc_vc    <= bus.long_pkt_v_channel_i;
               r_word_cnt  <= bus.long_pkt_word_cnt_i;
               r_byte_cnt  <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tvalid <= '0;
         r_tuser  <= '0;
         r_tlast  <= '0;
         for (int v = 0; v < VC_CNT; v++) begin
            r_tdata[v] <= '0;
            r_tstrb[v] <= '0;
         end
      end else begin
         r_tvalid <= w_pay_vec;
         r_tlast  <= w_pay_vec & {VC_CNT{bus.long_pkt_eop_i}};
         for (int v = 0; v < VC_CNT; v++) begin
            r_tuser[v] <= w_pay_vec[v] && w_sof_pend[v];
            if (w_pay_vec[v]) begin
               r_tdata[v] <= bus.long_pkt_payload_i;
               r_tstrb[v] <= bus.long_pkt_payload_be_i;
            end
         end
      end
   end

   assign bus.vc_tvalid_o = r_tvalid;
   assign bus.vc_tuser_o  = r_tuser;
   assign bus.vc_tlast_o  = r_tlast;

   always_comb begin
      bus.vc_tdata_o     = '0;
      bus.vc_tstrb_o     = '0;
      bus.frame_active_o = '0;
      bus.frame_num_o    = '0;
      bus.line_cnt_o     = '0;
      bus.err_o          = '0;
      for (int v = 0; v < VC_CNT; v++) begin
         bus.vc_tdata_o[v*32 +: 32]                 = r_tdata[v];
         bus.vc_tstrb_o[v*4 +: 4]                   = r_tstrb[v];
         bus.frame_active_o[v]                      = w_frame_active[v];
         bus.frame_num_o[v*16 +: 16]                = w_frame_num[v];
         bus.line_cnt_o[v*LINE_CNT_W +: LINE_CNT_W] = w_line_cnt[v];
         bus.err_o[v*c_ERR_W +: c_ERR_W]            = w_err[v];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_csi2_vc_demux.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_csi2_vc_demux : directed and randomized scenarios against a reference model
// Rev 1.0
//----------------------------------------------------------------------------
module tb_csi2_vc_demux;

   localparam int VCN = 3;
   localparam int LW  = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   csi2_vc_demux_if #(.VC_CNT(VCN), .LINE_CNT_W(LW)) bus ();

   csi2_vc_demux #(
      .VC_CNT(VCN), .PIXEL_DT(6'h2B), .ACCEPT_ALL_DT(1'b0), .LINE_CNT_W(LW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference state: 0 = no frame, 1 = inside frame, 2 = inside a line
   int           m_st    [VCN];
   logic [15:0]  m_fn    [VCN];
   logic [LW-1:0] m_lc   [VCN];
   bit           m_sof   [VCN];
   logic [31:0]  m_data  [VCN];
   logic [3:0]   m_strb  [VCN];
   int           m_act, m_bytes, m_wc, m_crc_vc;
   bit           m_drop, m_crc_arm;
   logic [4:0]   obs_err [VCN];
   int           obs_beats [VCN];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      for (int v = 0; v < VCN; v++) begin
         obs_err[v]   = '0;
         obs_beats[v] = 0;
      end
   endtask

   // One clock: derive expected outputs from the current inputs, step, compare.
   task automatic cycle();
      bit         e_val [VCN];
      bit         e_usr [VCN];
      bit         e_lst [VCN];
      bit         done  [VCN];
      logic [4:0] e_err [VCN];
      int         a, s, hv;
      for (int v = 0; v < VCN; v++) begin
         e_val[v] = 0; e_usr[v] = 0; e_lst[v] = 0; done[v] = 0; e_err[v] = '0;
      end
      if (rst) begin
         for (int v = 0; v < VCN; v++) begin
            m_st[v] = 0; m_fn[v] = '0; m_lc[v] = '0; m_sof[v] = 0; m_data[v] = '0; m_strb[v] = '0;
         end
         m_act = 0; m_bytes = 0; m_wc = 0; m_crc_vc = 0; m_drop = 0; m_crc_arm = 0;
      end else begin
         if (bus.long_pkt_payload_valid_i) begin
            if (!m_drop && m_st[m_act] == 2) begin
               a = m_act;
               e_val[a] = 1; e_usr[a] = m_sof[a]; m_sof[a] = 0;
               m_data[a] = bus.long_pkt_payload_i;
               m_strb[a] = bus.long_pkt_payload_be_i;
               m_bytes += $countones(bus.long_pkt_payload_be_i);
               if (bus.long_pkt_eop_i) begin
                  e_lst[a] = 1; done[a] = 1;
                  if (m_bytes != m_wc) e_err[a][2] = 1'b1;
               end
            end
            if (bus.long_pkt_eop_i) m_drop = 0;
         end
         if (bus.short_pkt_valid_i && int'(bus.short_pkt_v_channel_i) < VCN) begin
            s = int'(bus.short_pkt_v_channel_i);
            if (bus.short_pkt_data_type_i == 6'h00) begin
               if (m_st[s] != 0) e_err[s][3] = 1'b1;
               m_st[s] = 1; m_fn[s] = bus.short_pkt_data_field_i; m_lc[s] = '0; m_sof[s] = 1; done[s] = 0;
            end else if (bus.short_pkt_data_type_i == 6'h01) begin
               if (m_st[s] == 0) e_err[s][4] = 1'b1;
               if (m_st[s] == 2) e_err[s][1] = 1'b1;
               m_st[s] = 0; done[s] = 0;
            end
         end
         for (int v = 0; v < VCN; v++)
            if (done[v]) begin m_st[v] = 1; m_lc[v] = m_lc[v] + 1'b1; end
         if (bus.crc_failed_i && m_crc_arm) e_err[m_crc_vc][0] = 1'b1;
         if (bus.long_pkt_header_valid_i) begin
            hv = int'(bus.long_pkt_v_channel_i);
            m_drop = 1; m_crc_arm = 0;
            if (bus.long_pkt_data_type_i == 6'h2B && hv < VCN) begin
               if (m_st[hv] == 1) begin
                  m_st[hv] = 2; m_act = hv; m_wc = int'(bus.long_pkt_word_cnt_i);
                  m_bytes = 0; m_drop = 0; m_crc_arm = 1; m_crc_vc = hv;
               end else if (m_st[hv] == 0) begin
                  e_err[hv][4] = 1'b1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      for (int v = 0; v < VCN; v++) begin
         chk($sformatf("vc%0d_tvalid", v), 32'(bus.vc_tvalid_o[v]), 32'(e_val[v]));
         chk($sformatf("vc%0d_tuser", v),  32'(bus.vc_tuser_o[v]),  32'(e_usr[v]));
         chk($sformatf("vc%0d_tlast", v),  32'(bus.vc_tlast_o[v]),  32'(e_lst[v]));
         chk($sformatf("vc%0d_tdata", v),  bus.vc_tdata_o[v*32 +: 32], m_data[v]);
         chk($sformatf("vc%0d_tstrb", v),  32'(bus.vc_tstrb_o[v*4 +: 4]), 32'(m_strb[v]));
         chk($sformatf("vc%0d_err", v),    32'(bus.err_o[v*5 +: 5]), 32'(e_err[v]));
         chk($sformatf("vc%0d_active", v), 32'(bus.frame_active_o[v]), 32'(m_st[v] != 0));
         chk($sformatf("vc%0d_fnum", v),   32'(bus.frame_num_o[v*16 +: 16]), 32'(m_fn[v]));
         chk($sformatf("vc%0d_lcnt", v),   32'(bus.line_cnt_o[v*LW +: LW]), 32'(m_lc[v]));
         obs_err[v] = obs_err[v] | bus.err_o[v*5 +: 5];
         if (bus.vc_tvalid_o[v]) obs_beats[v]++;
      end
      bus.short_pkt_valid_i        = 1'b0;
      bus.long_pkt_header_valid_i  = 1'b0;
      bus.long_pkt_payload_valid_i = 1'b0;
      bus.long_pkt_eop_i           = 1'b0;
      bus.crc_failed_i             = 1'b0;
      bus.crc_passed_i             = 1'b0;
   endtask

   task automatic set_short(input int vc, input int dt, input int field);
      bus.short_pkt_valid_i      = 1'b1;
      bus.short_pkt_v_channel_i  = vc[1:0];
      bus.short_pkt_data_type_i  = dt[5:0];
      bus.short_pkt_data_field_i = field[15:0];
   endtask

   task automatic set_hdr(input int vc, input int dt, input int wc);
      bus.long_pkt_header_valid_i = 1'b1;
      bus.long_pkt_v_channel_i    = vc[1:0];
      bus.long_pkt_data_type_i    = dt[5:0];
      bus.long_pkt_word_cnt_i     = wc[15:0];
   endtask

   task automatic short_pkt(input int vc, input int dt, input int field);
      set_short(vc, dt, field);
      cycle();
   endtask

   task automatic words(input int nw, input logic [3:0] last_be, input bit with_eop);
      for (int i = 0; i < nw; i++) begin
         bus.long_pkt_payload_valid_i = 1'b1;
         bus.long_pkt_payload_i       = $urandom;
         bus.long_pkt_payload_be_i    = (i == nw - 1) ? last_be : 4'hF;
         bus.long_pkt_eop_i           = with_eop && (i == nw - 1);
         cycle();
      end
   endtask

   task automatic long_line(input int vc, input int dt, input int wc, input int nw, input logic [3:0] last_be);
      set_hdr(vc, dt, wc);
      cycle();
      words(nw, last_be, 1'b1);
      cycle();
   endtask

   initial begin
      logic [3:0] be_tab [4];
      int vc, nw, wc, pick;
      be_tab[0] = 4'h1; be_tab[1] = 4'h3; be_tab[2] = 4'h7; be_tab[3] = 4'hF;
      rst = 1'b1;
      bus.short_pkt_valid_i = 1'b0; bus.short_pkt_v_channel_i = '0;
      bus.short_pkt_data_type_i = '0; bus.short_pkt_data_field_i = '0;
      bus.long_pkt_header_valid_i = 1'b0; bus.long_pkt_v_channel_i = '0;
      bus.long_pkt_data_type_i = '0; bus.long_pkt_word_cnt_i = '0;
      bus.long_pkt_payload_i = '0; bus.long_pkt_payload_valid_i = 1'b0;
      bus.long_pkt_payload_be_i = '0; bus.long_pkt_eop_i = 1'b0;
      bus.crc_passed_i = 1'b0; bus.crc_failed_i = 1'b0;
      cycle(); cycle();
      chk("reset_tvalid", 32'(bus.vc_tvalid_o), 32'h0);
      chk("reset_err", 32'(bus.err_o), 32'h0);
      rst = 1'b0;
      cycle();

      // Single frame on VC0: two 16-byte lines
      clear_obs();
      short_pkt(0, 6'h00, 16'h0005);
      long_line(0, 6'h2B, 16, 4, 4'hF);
      chk("s1_lcnt_after_line1", 32'(bus.line_cnt_o[LW-1:0]), 32'd1);
      long_line(0, 6'h2B, 16, 4, 4'hF);
      chk("s1_frame_num", 32'(bus.frame_num_o[15:0]), 32'h5);
      chk("s1_lcnt_after_line2", 32'(bus.line_cnt_o[LW-1:0]), 32'd2);
      short_pkt(0, 6'h01, 0);
      chk("s1_active_after_fe", 32'(bus.frame_active_o[0]), 32'd0);
      chk("s1_beats", 32'(obs_beats[0]), 32'd8);
      chk("s1_no_err", 32'(obs_err[0]), 32'h0);

      // Interleaved frames on VC1 and VC2
      clear_obs();
      short_pkt(1, 6'h00, $urandom_range(0, 65535));
      short_pkt(2, 6'h00, $urandom_range(0, 65535));
      long_line(2, 6'h2B, 12, 3, 4'hF);
      long_line(1, 6'h2B, 7, 2, 4'h7);
      chk("s2_vc1_lcnt", 32'(bus.line_cnt_o[LW +: LW]), 32'd1);
      chk("s2_vc2_lcnt", 32'(bus.line_cnt_o[2*LW +: LW]), 32'd1);
      short_pkt(1, 6'h01, 0);
      short_pkt(2, 6'h01, 0);
      chk("s2_vc1_beats", 32'(obs_beats[1]), 32'd2);
      chk("s2_vc2_beats", 32'(obs_beats[2]), 32'd3);
      chk("s2_no_err", 32'(obs_err[1] | obs_err[2]), 32'h0);

      // Short line: word_cnt 16, eop after 3 words
      clear_obs();
      short_pkt(0, 6'h00, 16'h0100);
      long_line(0, 6'h2B, 16, 3, 4'hF);
      chk("s3_len_err", 32'(obs_err[0]), 32'b00100);
      chk("s3_active", 32'(bus.frame_active_o[0]), 32'd1);
      short_pkt(0, 6'h01, 0);

      // Protocol errors: trunc, no_fs, no_fe
      clear_obs();
      short_pkt(1, 6'h00, 16'h0010);
      set_hdr(1, 6'h2B, 16); cycle();
      words(2, 4'hF, 1'b0);
      short_pkt(1, 6'h01, 0);
      words(2, 4'hF, 1'b1);
      short_pkt(1, 6'h01, 0);
      short_pkt(2, 6'h00, 16'h0020);
      short_pkt(2, 6'h00, 16'h0021);
      chk("s4_vc1_err", 32'(obs_err[1]), 32'b10010);
      chk("s4_vc2_err", 32'(obs_err[2]), 32'b01000);
      chk("s4_vc2_fnum", 32'(bus.frame_num_o[32 +: 16]), 32'h0021);

      // Filtering: rejected DT, VC beyond range, header without frame
      clear_obs();
      long_line(2, 6'h12, 8, 2, 4'hF);
      long_line(3, 6'h2B, 8, 2, 4'hF);
      short_pkt(3, 6'h00, 16'h0033);
      long_line(0, 6'h2B, 8, 2, 4'hF);
      chk("s5_beats", 32'(obs_beats[0] + obs_beats[1] + obs_beats[2]), 32'd0);
      chk("s5_vc0_err", 32'(obs_err[0]), 32'b10000);

      // CRC failure after VC2 line, then after a dropped packet
      clear_obs();
      long_line(2, 6'h2B, 8, 2, 4'hF);
      bus.crc_failed_i = 1'b1; cycle();
      long_line(2, 6'h2A, 8, 2, 4'hF);
      bus.crc_failed_i = 1'b1; cycle();
      chk("s6_vc2_err", 32'(obs_err[2]), 32'b00001);
      short_pkt(2, 6'h01, 0);

      // FS and header together on VC1
      set_short(1, 6'h00, 16'h0077);
      set_hdr(1, 6'h2B, 8);
      cycle();
      words(2, 4'hF, 1'b1);
      cycle();

      // Randomized lines across VCs
      for (int it = 0; it < 16; it++) begin
         vc = $urandom_range(0, VCN - 1);
         if (m_st[vc] == 0) short_pkt(vc, 6'h00, $urandom_range(0, 65535));
         nw   = $urandom_range(1, 5);
         pick = $urandom_range(0, 3);
         wc   = (nw - 1) * 4 + $countones(be_tab[pick]);
         if ($urandom_range(0, 3) == 0) wc = wc + 1;
         long_line(vc, ($urandom_range(0, 5) == 0) ? 6'h2A : 6'h2B, wc, nw, be_tab[pick]);
         if ($urandom_range(0, 4) == 0) short_pkt(vc, 6'h01, 0);
      end

      // Reset in the middle of a line
      short_pkt(0, 6'h00, 16'h0099);
      set_hdr(0, 6'h2B, 16); cycle();
      words(2, 4'hF, 1'b0);
      rst = 1'b1;
      bus.long_pkt_payload_valid_i = 1'b1;
      bus.long_pkt_payload_be_i    = 4'hF;
      bus.long_pkt_eop_i           = 1'b1;
      cycle();
      chk("rst_tvalid", 32'(bus.vc_tvalid_o), 32'h0);
      chk("rst_tlast", 32'(bus.vc_tlast_o), 32'h0);
      chk("rst_active", 32'(bus.frame_active_o), 32'h0);
      rst = 1'b0;
      cycle();
      short_pkt(0, 6'h00, 16'h00AA);
      long_line(0, 6'h2B, 4, 1, 4'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
